// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory with FIXED/INCR/WRAP bursts and ID-tagged responses.
// Independent read and write engines, one outstanding transaction each.
module axi4_slave_mem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 11,
    parameter int MEM_DEPTH = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     aw_id,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic [7:0]          aw_len,
    input  logic [2:0]          aw_size,
    input  logic [1:0]          aw_burst,
    input  logic                aw_valid,
    output logic                aw_ready,
    input  logic [DATA_W-1:0]   dw_data,
    input  logic [DATA_W/8-1:0] dw_strb,
    input  logic                dw_last,
    input  logic                dw_valid,
    output logic                dw_ready,
    output logic [ID_W-1:0]     b_id,
    output logic [1:0]          b_resp,
    output logic                b_valid,
    input  logic                b_ready,
    input  logic [ID_W-1:0]     ar_id,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic [7:0]          ar_len,
    input  logic [2:0]          ar_size,
    input  logic [1:0]          ar_burst,
    input  logic                ar_valid,
    output logic                ar_ready,
    output logic [ID_W-1:0]     dr_id,
    output logic [DATA_W-1:0]   dr_data,
    output logic [1:0]          dr_resp,
    output logic                dr_last,
    output logic                dr_valid,
    input  logic                dr_ready
);
    localparam int NB  = DATA_W / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    function automatic logic wrap_ok(input logic [7:0] len);
        return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    endfunction

    function automatic logic size_bad(input logic [2:0] size);
        return int'(size) > LSB;
    endfunction

    function automatic logic cmd_bad(input logic [1:0] burst,
                                     input logic [7:0] len,
                                     input logic [2:0] size);
        return burst == 2'b11 || (burst == 2'b10 && !wrap_ok(len))
            || size_bad(size);
    endfunction

    // Illegal WRAP and reserved bursts fall back to INCR.
    function automatic logic [1:0] eff_burst(input logic [1:0] burst,
                                             input logic [7:0] len);
        if (burst == 2'b00) return 2'b00;
        if (burst == 2'b10 && wrap_ok(len)) return 2'b10;
        return 2'b01;
    endfunction

    function automatic logic [ADDR_W-1:0] step_addr(
        input logic [ADDR_W-1:0] a, input logic [2:0] size,
        input logic [1:0] burst, input logic [7:0] len);
        logic [ADDR_W-1:0] span, lo, nxt;
        span = (ADDR_W'(len) + A_ONE) << size;
        lo   = a & ~(span - A_ONE);
        nxt  = a + (A_ONE << size);
        case (burst)
            2'b00:   return a;
            2'b10:   return (nxt == lo + span) ? lo : nxt;
            default: return nxt;
        endcase
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> LSB) < ADDR_W'(MEM_DEPTH);
    endfunction

    // ---------------- write engine ----------------
    w_state_t          w_state, w_next;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err, w_size_err;
    logic              aw_fire, w_fire, w_final, w_beat_err, w_we;

    assign aw_fire    = aw_valid && aw_ready;
    assign w_fire     = dw_valid && dw_ready;
    assign w_final    = w_cnt == w_len;
    assign w_beat_err = !in_range(w_addr) || (dw_last != w_final);
    assign w_we       = w_fire && in_range(w_addr) && !w_size_err;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_next = W_DATA;
            W_DATA:  if (w_fire && w_final) w_next = W_RESP;
            W_RESP:  if (b_valid && b_ready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state    <= W_IDLE;
            aw_ready   <= 1'b0;
            dw_ready   <= 1'b0;
            b_valid    <= 1'b0;
            b_id       <= '0;
            b_resp     <= 2'b00;
            w_id       <= '0;
            w_addr     <= '0;
            w_len      <= '0;
            w_cnt      <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            w_err      <= 1'b0;
            w_size_err <= 1'b0;
        end else begin
            w_state  <= w_next;
            aw_ready <= w_next == W_IDLE;
            dw_ready <= w_next == W_DATA;
            b_valid  <= w_next == W_RESP;
            if (aw_fire) begin
                w_id       <= aw_id;
                w_addr     <= aw_addr;
                w_len      <= aw_len;
                w_size     <= aw_size;
                w_burst    <= eff_burst(aw_burst, aw_len);
                w_cnt      <= '0;
                w_err      <= cmd_bad(aw_burst, aw_len, aw_size);
                w_size_err <= size_bad(aw_size);
            end
            if (w_fire) begin
                w_cnt  <= w_cnt + 8'd1;
                w_addr <= step_addr(w_addr, w_size, w_burst, w_len);
                w_err  <= w_err | w_beat_err;
                if (w_final) begin
                    b_id   <= w_id;
                    b_resp <= (w_err | w_beat_err) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (dw_strb[i])
                    mem[w_addr[LSB +: IW]][8*i +: 8] <= dw_data[8*i +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t          r_state, r_next;
    logic [ADDR_W-1:0] r_addr, rs_addr;
    logic [7:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst, rs_resp;
    logic              r_err, r_size_err, rs_serr, rs_cerr, rs_in;
    logic [DATA_W-1:0] rs_data;
    logic              ar_fire, r_fire, r_final;

    assign ar_fire = ar_valid && ar_ready;
    assign r_fire  = dr_valid && dr_ready;
    assign r_final = r_cnt == r_len;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_next = R_DATA;
            R_DATA:  if (r_fire && r_final) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Beat to present next: first beat of a new command or the following one.
    always_comb begin
        rs_addr = step_addr(r_addr, r_size, r_burst, r_len);
        rs_serr = r_size_err;
        rs_cerr = r_err;
        if (ar_fire) begin
            rs_addr = ar_addr;
            rs_serr = size_bad(ar_size);
            rs_cerr = cmd_bad(ar_burst, ar_len, ar_size);
        end
        rs_in   = in_range(rs_addr);
        rs_data = (rs_in && !rs_serr) ? mem[rs_addr[LSB +: IW]] : '0;
        rs_resp = (rs_cerr || !rs_in) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= R_IDLE;
            ar_ready   <= 1'b0;
            dr_valid   <= 1'b0;
            dr_id      <= '0;
            dr_data    <= '0;
            dr_resp    <= 2'b00;
            dr_last    <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_err      <= 1'b0;
            r_size_err <= 1'b0;
        end else begin
            r_state  <= r_next;
            ar_ready <= r_next == R_IDLE;
            dr_valid <= r_next == R_DATA;
            if (ar_fire) begin
                r_addr     <= ar_addr;
                r_len      <= ar_len;
                r_size     <= ar_size;
                r_burst    <= eff_burst(ar_burst, ar_len);
                r_cnt      <= '0;
                r_err      <= rs_cerr;
                r_size_err <= rs_serr;
                dr_id      <= ar_id;
                dr_data    <= rs_data;
                dr_resp    <= rs_resp;
                dr_last    <= ar_len == 8'd0;
            end else if (r_fire && !r_final) begin
                r_addr  <= rs_addr;
                r_cnt   <= r_cnt + 8'd1;
                dr_data <= rs_data;
                dr_resp <= rs_resp;
                dr_last <= (r_cnt + 8'd1) == r_len;
            end
        end
    end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed scoreboard bench for axi4_slave_mem.
// Expected B and R results are queued at issue and checked on completion.
module tb_axi4_slave_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] aw_id, ar_id, b_id, dr_id;
    logic [31:0] aw_addr, ar_addr, dw_data, dr_data;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, dr_resp;
    logic [3:0]  dw_strb;
    logic        aw_valid, aw_ready, dw_last, dw_valid, dw_ready;
    logic        b_valid, b_ready, ar_valid, ar_ready;
    logic        dr_last, dr_valid, dr_ready;

    axi4_slave_mem dut (
        .clk(clk), .rst(rst),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .dw_data(dw_data), .dw_strb(dw_strb), .dw_last(dw_last),
        .dw_valid(dw_valid), .dw_ready(dw_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .dr_id(dr_id), .dr_data(dr_data), .dr_resp(dr_resp),
        .dr_last(dr_last), .dr_valid(dr_valid), .dr_ready(dr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] id;
        logic [1:0]  resp;
    } bexp_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [10:0] id;
    } rexp_t;

    bexp_t       exp_b[$];
    rexp_t       exp_r[$];
    logic [31:0] wd [16];
    int          errors = 0;
    int          checks = 0;

    logic [63:0] outs;
    assign outs = {aw_ready, dw_ready, b_valid, b_id, b_resp, ar_ready,
                   dr_valid, dr_id, dr_data, dr_resp, dr_last};

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_r(input logic [10:0] id, input logic [31:0] d,
                          input logic [1:0] r, input logic l);
        rexp_t e;
        e.id = id; e.data = d; e.resp = r; e.last = l;
        exp_r.push_back(e);
    endtask

    task automatic do_write(input logic [10:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] strb, input int last_beat,
                            input logic [1:0] eresp, input int abort_beat);
        bexp_t e;
        int n;
        @(negedge clk);
        aw_valid = 1; aw_id = id; aw_addr = addr; aw_len = len;
        aw_size = 3'd2; aw_burst = burst;
        e.id = id; e.resp = eresp;
        exp_b.push_back(e);
        n = 0;
        while (!aw_ready && n < 50) begin @(negedge clk); n++; end
        check("aw_accept", aw_ready, 1);
        @(negedge clk);
        aw_valid = 0;
        check("aw_ready_drop", aw_ready, 0);
        check("dw_ready_lat", dw_ready, 1);
        for (int b = 0; b <= int'(len); b++) begin
            if (b == abort_beat) begin
                dw_valid = 0; dw_last = 0;
                rst = 1;
                #1;
                check("rst_outs_zero", outs, 0);
                void'(exp_b.pop_back());
                return;
            end
            dw_valid = 1; dw_data = wd[b]; dw_strb = strb;
            dw_last = (b == last_beat);
            n = 0;
            while (!dw_ready && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        dw_valid = 0; dw_last = 0;
        check("b_valid_lat", b_valid, 1);
        b_ready = 1;
        n = 0;
        while (!b_valid && n < 50) begin @(negedge clk); n++; end
        if (exp_b.size() == 0) begin
            check("b_underflow", 1, 0);
        end else begin
            e = exp_b.pop_front();
            check("b_id", b_id, e.id);
            check("b_resp", b_resp, e.resp);
        end
        @(negedge clk);
        b_ready = 0;
    endtask

    task automatic do_read(input logic [10:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit toggle);
        rexp_t e;
        int n, beats, cyc;
        logic rdy;
        @(negedge clk);
        ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len;
        ar_size = size; ar_burst = burst;
        n = 0;
        while (!ar_ready && n < 50) begin @(negedge clk); n++; end
        check("ar_accept", ar_ready, 1);
        @(negedge clk);
        ar_valid = 0;
        check("dr_valid_lat", dr_valid, 1);
        beats = 0; cyc = 0;
        while (beats <= int'(len) && cyc < 400) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            dr_ready = rdy;
            if (dr_valid) begin
                if (exp_r.size() == 0) begin
                    check("r_underflow", 1, 0);
                end else begin
                    e = exp_r[0];
                    check("dr_data", dr_data, e.data);
                    check("dr_resp", dr_resp, e.resp);
                    check("dr_last", dr_last, e.last);
                    check("dr_id", dr_id, e.id);
                    if (rdy) begin
                        void'(exp_r.pop_front());
                        beats++;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        dr_ready = 0;
        check("r_beats", beats, int'(len) + 1);
        check("dr_valid_end", dr_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0;
        aw_size = 0; aw_burst = 0;
        dw_valid = 0; dw_data = 0; dw_strb = 0; dw_last = 0;
        b_ready = 0; dr_ready = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0;
        ar_size = 0; ar_burst = 0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs, 0);
        rst = 0;
        @(negedge clk);
        check("aw_ready_post_rst", aw_ready, 1);
        check("ar_ready_post_rst", ar_ready, 1);

        // single beat write / read
        wd[0] = 32'hDEADBEEF;
        do_write(11'h5A5, 32'h10, 0, 2'b01, 4'hF, 0, 2'b00, -1);
        push_r(11'h123, 32'hDEADBEEF, 2'b00, 1);
        do_read(11'h123, 32'h10, 0, 3'd2, 2'b01, 0);

        // INCR burst read back under backpressure
        for (int i = 0; i < 4; i++) wd[i] = i + 1;
        do_write(11'h011, 32'h40, 3, 2'b01, 4'hF, 3, 2'b00, -1);
        for (int i = 0; i < 4; i++) push_r(11'h022, i + 1, 2'b00, i == 3);
        do_read(11'h022, 32'h40, 3, 3'd2, 2'b01, 1);

        // WRAP
        wd[0] = 32'hAAAA0000; wd[1] = 32'hBBBB1111;
        wd[2] = 32'hCCCC2222; wd[3] = 32'hDDDD3333;
        do_write(11'h033, 32'h00, 3, 2'b01, 4'hF, 3, 2'b00, -1);
        push_r(11'h044, 32'hCCCC2222, 2'b00, 0);
        push_r(11'h044, 32'hDDDD3333, 2'b00, 0);
        push_r(11'h044, 32'hAAAA0000, 2'b00, 0);
        push_r(11'h044, 32'hBBBB1111, 2'b00, 1);
        do_read(11'h044, 32'h08, 3, 3'd2, 2'b10, 0);

        // byte strobes
        wd[0] = 32'hFFFFFFFF;
        do_write(11'h055, 32'h20, 0, 2'b01, 4'hF, 0, 2'b00, -1);
        wd[0] = 32'h00000000;
        do_write(11'h056, 32'h20, 0, 2'b01, 4'b0101, 0, 2'b00, -1);
        push_r(11'h057, 32'hFF00FF00, 2'b00, 1);
        do_read(11'h057, 32'h20, 0, 3'd2, 2'b01, 0);

        // FIXED burst keeps hitting one word
        for (int i = 0; i < 4; i++) wd[i] = i + 1;
        do_write(11'h066, 32'h30, 3, 2'b00, 4'hF, 3, 2'b00, -1);
        push_r(11'h067, 32'd4, 2'b00, 1);
        do_read(11'h067, 32'h30, 0, 3'd2, 2'b01, 0);

        // top-of-memory read crossing out of range
        wd[0] = 32'h12345678;
        do_write(11'h077, 32'h3FC, 0, 2'b01, 4'hF, 0, 2'b00, -1);
        push_r(11'h078, 32'h12345678, 2'b00, 0);
        push_r(11'h078, 32'h0, 2'b10, 1);
        do_read(11'h078, 32'h3FC, 1, 3'd2, 2'b01, 0);

        // early dw_last, out-of-range write
        wd[0] = 32'h5; wd[1] = 32'h6;
        do_write(11'h088, 32'h70, 1, 2'b01, 4'hF, 0, 2'b10, -1);
        do_write(11'h089, 32'h400, 0, 2'b01, 4'hF, 0, 2'b10, -1);

        // reserved burst and oversize reads
        push_r(11'h099, 32'd1, 2'b10, 0);
        push_r(11'h099, 32'd2, 2'b10, 1);
        do_read(11'h099, 32'h40, 1, 3'd2, 2'b11, 0);
        push_r(11'h09A, 32'h0, 2'b10, 1);
        do_read(11'h09A, 32'h40, 0, 3'd3, 2'b01, 0);

        // concurrent write and read bursts
        for (int i = 0; i < 8; i++) wd[i] = 32'h600 + i;
        do_write(11'h0A0, 32'h60, 7, 2'b01, 4'hF, 7, 2'b00, -1);
        for (int i = 0; i < 8; i++) wd[i] = 32'h800 + i;
        for (int i = 0; i < 8; i++)
            push_r(11'h0A2, 32'h600 + i, 2'b00, i == 7);
        fork
            do_write(11'h0A1, 32'h80, 7, 2'b01, 4'hF, 7, 2'b00, -1);
            do_read(11'h0A2, 32'h60, 7, 3'd2, 2'b01, 0);
        join
        for (int i = 0; i < 8; i++)
            push_r(11'h0A3, 32'h800 + i, 2'b00, i == 7);
        do_read(11'h0A3, 32'h80, 7, 3'd2, 2'b01, 0);

        // reset during beat 3 of a write
        for (int i = 0; i < 8; i++) wd[i] = 32'hA00 + i;
        do_write(11'h0B0, 32'hA0, 7, 2'b01, 4'hF, 7, 2'b00, 3);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("aw_ready_after_abort", aw_ready, 1);
        check("b_valid_after_abort", b_valid, 0);
        for (int i = 0; i < 3; i++)
            push_r(11'h0B1, 32'hA00 + i, 2'b00, i == 2);
        do_read(11'h0B1, 32'hA0, 2, 3'd2, 2'b01, 0);

        check("b_queue_empty", exp_b.size(), 0);
        check("r_queue_empty", exp_r.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
